// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel push-button debouncer for the clock/alarm board.
// Each channel has a two-flop synchroniser and a stability counter that produce
// a clean level plus one-cycle press/release pulses. An optional auto-repeat
// engine adds "step" ticks while a button is held. The mode enable gates
// qualification on every channel.
// The release pulse port is named release_o because "release" is a reserved
// word in SystemVerilog.
module debounce_multi #(
  parameter int N_CH        = 4,
  parameter int STABLE_CYC  = 500000,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_RATE = 5000000
) (
  input  logic            cclk,
  input  logic            clr,
  input  logic            en,
  input  logic [N_CH-1:0] inp,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] step
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [N_CH-1:0] step_q, step_d;
  logic [N_CH-1:0] tick_s;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];

  // Synchroniser shift and per-channel stability qualification.
  always_comb begin
    sync1_d   = inp;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = {N_CH{1'b0}};
    release_d = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = {CW{1'b0}};
      if (en && (sync2_q[i] != level_q[i])) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  // Step is the press pulse merged with any repeat tick.
  assign step_d = press_d | tick_s;

  // Register synchronisers, counters and all outputs; clr overrides everything.
  always_ff @(posedge cclk) begin
    if (clr) begin
      sync1_q   <= {N_CH{1'b0}};
      sync2_q   <= {N_CH{1'b0}};
      level_q   <= {N_CH{1'b0}};
      press_q   <= {N_CH{1'b0}};
      release_q <= {N_CH{1'b0}};
      step_q    <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  generate
    if (REPEAT_DLY > 0) begin : g_rep
      localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
      localparam int RW   = $clog2(RMAX + 1);
      // Reload so that the next tick lands exactly REPEAT_RATE cycles later
      // (assumes REPEAT_RATE <= REPEAT_DLY).
      localparam logic [RW-1:0] RCNT_TICK   = RW'(REPEAT_DLY - 1);
      localparam logic [RW-1:0] RCNT_RELOAD = RW'(REPEAT_DLY - REPEAT_RATE);

      typedef enum logic {IDLE = 1'b0, HELD = 1'b1} rep_state_t;

      rep_state_t    state_q [N_CH];
      rep_state_t    state_d [N_CH];
      logic [RW-1:0] rcnt_q  [N_CH];
      logic [RW-1:0] rcnt_d  [N_CH];

      // Repeat FSM next state: arm on press, tick while held, release wins.
      always_comb begin
        tick_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
          state_d[i] = state_q[i];
          rcnt_d[i]  = rcnt_q[i];
          case (state_q[i])
            IDLE: begin
              rcnt_d[i] = {RW{1'b0}};
              if (press_d[i]) begin
                state_d[i] = HELD;
              end else begin
                state_d[i] = IDLE;
              end
            end
            HELD: begin
              if (!en || release_d[i]) begin
                state_d[i] = IDLE;
                rcnt_d[i]  = {RW{1'b0}};
              end else if (rcnt_q[i] == RCNT_TICK) begin
                tick_s[i] = 1'b1;
                rcnt_d[i] = RCNT_RELOAD;
              end else begin
                rcnt_d[i] = rcnt_q[i] + RW'(1);
              end
            end
            default: begin
              state_d[i] = IDLE;
              rcnt_d[i]  = {RW{1'b0}};
            end
          endcase
        end
      end

      // Repeat FSM state and counter registers.
      always_ff @(posedge cclk) begin
        for (int i = 0; i < N_CH; i++) begin
          if (clr) begin
            state_q[i] <= IDLE;
            rcnt_q[i]  <= {RW{1'b0}};
          end else begin
            state_q[i] <= state_d[i];
            rcnt_q[i]  <= rcnt_d[i];
          end
        end
      end
    end else begin : g_norep
      assign tick_s = {N_CH{1'b0}};
    end
  endgenerate

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;
  assign step      = step_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed phases plus randomized bouncing, checked
// each cycle against a behavioural model (run lengths, press-time arithmetic).
module tb_debounce_multi;

  localparam int STAB = 4;
  localparam int RDLY = 10;
  localparam int RRATE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        en;
  logic [3:0]  inp_a;
  logic [15:0] inp_w;
  logic [3:0]  lvl_a, prs_a, rel_a, stp_a;
  logic [15:0] lvl_w, prs_w, rel_w, stp_w;
  logic [0:0]  lvl_n, prs_n, rel_n, stp_n;

  debounce_multi #(.N_CH(4), .STABLE_CYC(STAB), .REPEAT_DLY(RDLY), .REPEAT_RATE(RRATE)) u_a (
    .cclk(clk), .clr(clr), .en(en), .inp(inp_a),
    .level(lvl_a), .press(prs_a), .release_o(rel_a), .step(stp_a));

  debounce_multi #(.N_CH(16), .STABLE_CYC(STAB), .REPEAT_DLY(0), .REPEAT_RATE(1)) u_w (
    .cclk(clk), .clr(clr), .en(en), .inp(inp_w),
    .level(lvl_w), .press(prs_w), .release_o(rel_w), .step(stp_w));

  debounce_multi #(.N_CH(1), .STABLE_CYC(STAB), .REPEAT_DLY(0), .REPEAT_RATE(1)) u_n (
    .cclk(clk), .clr(clr), .en(en), .inp(inp_w[0:0]),
    .level(lvl_n), .press(prs_n), .release_o(rel_n), .step(stp_n));

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Model state: index 0 = repeat-enabled 4-channel unit, 1 = 16-channel unit.
  bit m_s1 [2][16];
  bit m_s2 [2][16];
  bit m_lvl [2][16];
  bit m_held [2][16];
  bit m_p [2][16];
  bit m_r [2][16];
  bit m_s [2][16];
  int m_run [2][16];
  int m_pst [2][16];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at edge %0d", tag, got, exp, t);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int nch = (d == 0) ? 4 : 16;
      int dly = (d == 0) ? RDLY : 0;
      for (int c = 0; c < nch; c++) begin
        bit in_b = (d == 0) ? inp_a[c] : inp_w[c];
        if (clr) begin
          m_s1[d][c] = 1'b0; m_s2[d][c] = 1'b0; m_lvl[d][c] = 1'b0;
          m_held[d][c] = 1'b0; m_run[d][c] = 0;
          m_p[d][c] = 1'b0; m_r[d][c] = 1'b0; m_s[d][c] = 1'b0;
        end else begin
          m_p[d][c] = 1'b0; m_r[d][c] = 1'b0; m_s[d][c] = 1'b0;
          if (en && (m_s2[d][c] != m_lvl[d][c])) begin
            m_run[d][c]++;
            if (m_run[d][c] == STAB) begin
              m_lvl[d][c] = m_s2[d][c];
              m_run[d][c] = 0;
              if (m_lvl[d][c]) m_p[d][c] = 1'b1;
              else m_r[d][c] = 1'b1;
            end
          end else begin
            m_run[d][c] = 0;
          end
          if (dly != 0) begin
            if (!en || m_r[d][c]) begin
              m_held[d][c] = 1'b0;
            end else if (m_held[d][c] && (t - m_pst[d][c]) >= dly &&
                         ((t - m_pst[d][c] - dly) % RRATE) == 0) begin
              m_s[d][c] = 1'b1;
            end
            if (m_p[d][c]) begin
              m_held[d][c] = 1'b1;
              m_pst[d][c] = t;
            end
          end
          if (m_p[d][c]) m_s[d][c] = 1'b1;
          m_s2[d][c] = m_s1[d][c];
          m_s1[d][c] = in_b;
        end
      end
    end
  endtask

  // One clock: step the model at the edge, then compare all outputs 1 ns later.
  task automatic tick();
    logic [15:0] el [2];
    logic [15:0] ep [2];
    logic [15:0] er [2];
    logic [15:0] es [2];
    @(posedge clk);
    t++;
    model_edge();
    #1;
    for (int d = 0; d < 2; d++) begin
      el[d] = 16'h0; ep[d] = 16'h0; er[d] = 16'h0; es[d] = 16'h0;
      for (int c = 0; c < 16; c++) begin
        el[d][c] = m_lvl[d][c]; ep[d][c] = m_p[d][c];
        er[d][c] = m_r[d][c];   es[d][c] = m_s[d][c];
      end
    end
    chk("a_level",   {12'h000, lvl_a}, el[0] & 16'h000f);
    chk("a_press",   {12'h000, prs_a}, ep[0] & 16'h000f);
    chk("a_release", {12'h000, rel_a}, er[0] & 16'h000f);
    chk("a_step",    {12'h000, stp_a}, es[0] & 16'h000f);
    chk("w_level",   lvl_w, el[1]);
    chk("w_press",   prs_w, ep[1]);
    chk("w_release", rel_w, er[1]);
    chk("w_step",    stp_w, es[1]);
    chk("w_step_eq_press", stp_w, prs_w);
    chk("n_all", {12'h000, lvl_n, prs_n, rel_n, stp_n},
        {12'h000, el[1][0], ep[1][0], er[1][0], es[1][0]});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int nst;
  int hc [4];

  initial begin
    clr = 1'b1; en = 1'b1; inp_a = 4'h0; inp_w = 16'h0000;
    ticks(2);
    chk("rst_outs", {lvl_a, prs_a, rel_a, stp_a}, 16'h0000);
    chk("rst_outs_w", lvl_w | prs_w | rel_w | stp_w, 16'h0000);

    // Latency: input rises before edge 1, level/press/step at edge 6.
    clr = 1'b0; inp_a[0] = 1'b1;
    ticks(5);
    chk("lat_early", {12'h000, lvl_a}, 16'h0000);
    tick();
    chk("lat_press", {12'h000, prs_a}, 16'h0001);
    chk("lat_step",  {12'h000, stp_a}, 16'h0001);
    chk("lat_level", {12'h000, lvl_a}, 16'h0001);
    tick();
    chk("lat_pulse_once", {12'h000, prs_a}, 16'h0000);

    // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted.
    inp_a[1] = 1'b1; ticks(3); inp_a[1] = 1'b0; ticks(10);
    chk("glitch_lvl", {15'h0000, lvl_a[1]}, 16'h0000);
    inp_a[1] = 1'b1; ticks(4); inp_a[1] = 1'b0; ticks(12);

    // Auto-repeat: press at tick 6, then steps at 16,19,22,25,28.
    nst = 0;
    inp_a[2] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (stp_a[2]) nst++;
    end
    chk("rep_steps", nst[15:0], 16'd6);
    inp_a[2] = 1'b0; ticks(15);

    // Enable gating: no qualification with en low, press STABLE cycles after en.
    en = 1'b0; inp_a[3] = 1'b1; ticks(10);
    chk("en_gate", {15'h0000, lvl_a[3]}, 16'h0000);
    en = 1'b1; ticks(4);
    chk("en_press", {15'h0000, prs_a[3]}, 16'h0001);
    ticks(15);
    en = 1'b0; ticks(5);
    chk("en_drop_step", {12'h000, stp_a}, 16'h0000);
    en = 1'b1; inp_a[3] = 1'b0; ticks(10);

    // Simultaneous presses on channels 0 and 3.
    clr = 1'b1; inp_a = 4'h0; tick();
    clr = 1'b0; inp_a = 4'b1001; ticks(6);
    chk("simul", {12'h000, prs_a}, 16'h0009);

    // clr mid-count restarts full qualification.
    inp_a = 4'h0; ticks(10);
    inp_a[1] = 1'b1; ticks(4);
    clr = 1'b1; tick();
    chk("clr_mid", {lvl_a, prs_a, rel_a, stp_a}, 16'h0000);
    clr = 1'b0; ticks(5);
    chk("requal_early", {15'h0000, lvl_a[1]}, 16'h0000);
    tick();
    chk("requal", {15'h0000, lvl_a[1]}, 16'h0001);

    // Randomized bouncing on all units.
    for (int c = 0; c < 4; c++) hc[c] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (hc[c] == 0) begin
          inp_a[c] = ~inp_a[c];
          hc[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 50);
        end else begin
          hc[c]--;
        end
      end
      for (int c = 0; c < 16; c++) begin
        if ($urandom_range(0, 5) == 0) inp_w[c] = ~inp_w[c];
      end
      if ($urandom_range(0, 149) == 0) en = ~en;
      clr = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
